// File: rtl/hazard_ctrl_pkg.sv
// Shared RV32I definitions for the pipeline hazard controller: base opcodes,
// writeback-source encoding, the sequencing FSM state encoding and a decoder
// that reports which source registers an opcode reads.
package riscv_defs;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  // Writeback source value that identifies a load in EX.
  localparam logic [1:0] RESULT_SEL_MEM = 2'b01;

  typedef enum logic [1:0] {
    ST_RESET_FLUSH = 2'd0,
    ST_RUN         = 2'd1,
    ST_MEM_WAIT    = 2'd2
  } hz_state_t;

  // Returns {uses_rs2, uses_rs1}; LUI, AUIPC, JAL and unknown opcodes read nothing.
  function automatic logic [1:0] rs_usage(input logic [6:0] opcode);
    logic [1:0] use_rs;
    use_rs = 2'b00;
    case (opcode)
      OPC_OP, OPC_STORE, OPC_BRANCH: use_rs = 2'b11;
      OPC_OP_IMM, OPC_LOAD, OPC_JALR: use_rs = 2'b01;
      default:                        use_rs = 2'b00;
    endcase
    return use_rs;
  endfunction

endpackage

// File: rtl/hazard_ctrl_perf_cnt.sv
// Saturating hazard performance counters (built only with HAZARD_PERF_EN).
// Each counter advances by at most one per cycle and sticks at all-ones.
module hazard_perf_cnt #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_inc_stall,
  input  logic                 i_inc_flush,
  input  logic                 i_inc_lu,
  output logic [CNT_WIDTH-1:0] o_cnt_stall,
  output logic [CNT_WIDTH-1:0] o_cnt_flush,
  output logic [CNT_WIDTH-1:0] o_cnt_lu
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [CNT_WIDTH-1:0] r_cnt_stall;
  logic [CNT_WIDTH-1:0] r_cnt_flush;
  logic [CNT_WIDTH-1:0] r_cnt_lu;

  // Count strobes, clearing on reset and saturating at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt_stall <= '0;
      r_cnt_flush <= '0;
      r_cnt_lu    <= '0;
    end else begin
      if (i_inc_stall && (r_cnt_stall != CNT_MAX)) r_cnt_stall <= r_cnt_stall + 1'b1;
      if (i_inc_flush && (r_cnt_flush != CNT_MAX)) r_cnt_flush <= r_cnt_flush + 1'b1;
      if (i_inc_lu    && (r_cnt_lu    != CNT_MAX)) r_cnt_lu    <= r_cnt_lu + 1'b1;
    end
  end

  assign o_cnt_stall = r_cnt_stall;
  assign o_cnt_flush = r_cnt_flush;
  assign o_cnt_lu    = r_cnt_lu;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage RV32I core.
// Detects load-use hazards (ID vs load in EX), applies EX-resolved redirect
// flushes, freezes the pipe while data memory is busy and runs a sticky
// memory-wait watchdog. Stall/flush outputs are combinational from the
// inputs and the registered state, so they act in the cycle of their cause.
// Optional perf counters: define HAZARD_PERF_EN.
// o_dbg_state exposes the FSM state for observation.
module hazard_ctrl
  import riscv_defs::*;
#(
  parameter int MEM_TIMEOUT = 1024,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [6:0]           opcode_ID,
  input  logic [4:0]           rs1_ID,
  input  logic [4:0]           rs2_ID,
  input  logic [4:0]           rd_EX,
  input  logic                 reg_write_EX,
  input  logic [1:0]           result_sel_EX,
  input  logic                 redirect_EX,
  input  logic                 mem_busy_MEM,
  output logic                 stall_IF,
  output logic                 stall_ID,
  output logic                 stall_EX,
  output logic                 stall_MEM,
  output logic                 flush_ID,
  output logic                 flush_EX,
  output logic                 mem_timeout,
`ifdef HAZARD_PERF_EN
  output logic [CNT_WIDTH-1:0] cnt_stall,
  output logic [CNT_WIDTH-1:0] cnt_flush,
  output logic [CNT_WIDTH-1:0] cnt_lu,
`endif
  output logic [1:0]           o_dbg_state
);

  localparam logic [16:0] WD_LIMIT = 17'(MEM_TIMEOUT);

  hz_state_t   r_state;
  hz_state_t   w_next_state;
  logic [15:0] r_wd_cnt;
  logic        r_timeout;
  logic [1:0]  w_use_rs;
  logic        w_lu;
  logic        w_cnt_en;
  logic [16:0] w_cnt_now;
  logic        w_to_hit;

  assign w_use_rs = rs_usage(opcode_ID);
  assign w_lu = reg_write_EX && (result_sel_EX == RESULT_SEL_MEM) && (rd_EX != 5'd0) &&
                ((w_use_rs[0] && (rd_EX == rs1_ID)) || (w_use_rs[1] && (rd_EX == rs2_ID)));

  // Next state and Mealy stall/flush outputs; a MEM_WAIT cycle with busy low
  // follows the RUN rules, so both states share one branch. w_cnt_now is the
  // watchdog count including the current busy cycle.
  always_comb begin
    w_next_state = r_state;
    stall_IF     = 1'b0;
    stall_ID     = 1'b0;
    stall_EX     = 1'b0;
    stall_MEM    = 1'b0;
    flush_ID     = 1'b0;
    flush_EX     = 1'b0;
    w_cnt_en     = 1'b0;
    w_cnt_now    = 17'd0;
    if (rst) begin
      flush_ID     = 1'b1;
      flush_EX     = 1'b1;
      w_next_state = ST_RESET_FLUSH;
    end else begin
      case (r_state)
        ST_RUN, ST_MEM_WAIT: begin
          if (mem_busy_MEM) begin
            stall_IF     = 1'b1;
            stall_ID     = 1'b1;
            stall_EX     = 1'b1;
            stall_MEM    = 1'b1;
            w_next_state = ST_MEM_WAIT;
            w_cnt_en     = 1'b1;
            w_cnt_now    = (r_state == ST_RUN) ? 17'd1 : ({1'b0, r_wd_cnt} + 17'd1);
          end else begin
            w_next_state = ST_RUN;
            if (redirect_EX) begin
              flush_ID = 1'b1;
              flush_EX = 1'b1;
            end else if (w_lu) begin
              stall_IF = 1'b1;
              stall_ID = 1'b1;
              flush_EX = 1'b1;
            end
          end
        end
        default: begin
          flush_ID     = 1'b1;
          flush_EX     = 1'b1;
          w_next_state = ST_RUN;
        end
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_RESET_FLUSH;
    else     r_state <= w_next_state;
  end

  assign w_to_hit = w_cnt_en && (w_cnt_now >= WD_LIMIT);

  // Watchdog count (saturating at the limit) and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wd_cnt  <= 16'd0;
      r_timeout <= 1'b0;
    end else begin
      if (w_cnt_en) r_wd_cnt <= w_to_hit ? WD_LIMIT[15:0] : w_cnt_now[15:0];
      if (w_to_hit) r_timeout <= 1'b1;
    end
  end

  // The error shows in the very busy cycle that reaches the limit.
  assign mem_timeout = !rst && (r_timeout || w_to_hit);
  assign o_dbg_state = r_state;

`ifdef HAZARD_PERF_EN
  logic w_inc_flush;
  logic w_inc_lu;

  // Only the load-use bubble raises stall_ID together with flush_EX.
  assign w_inc_lu    = stall_ID && flush_EX;
  assign w_inc_flush = flush_ID && !rst && (r_state != ST_RESET_FLUSH);

  hazard_perf_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_perf (
    .clk         (clk),
    .rst         (rst),
    .i_inc_stall (stall_IF),
    .i_inc_flush (w_inc_flush),
    .i_inc_lu    (w_inc_lu),
    .o_cnt_stall (cnt_stall),
    .o_cnt_flush (cnt_flush),
    .o_cnt_lu    (cnt_lu)
  );
`endif

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline sequencing controller for the 5-stage RV32I core: decides each cycle whether IF/ID, ID/EX, EX/MEM and MEM/WB hold, advance or bubble. It detects load-use hazards between the instruction in ID and a load in EX, applies control-transfer flushes resolved in EX, and freezes the pipeline while the data-memory port is busy. A bounded memory-wait watchdog raises a sticky error. Optional hazard performance counters are included.

## Interface
- `MEM_TIMEOUT`, default 1024: maximum consecutive busy cycles before `mem_timeout` sets. Legal range is 2..65535.
- `CNT_WIDTH`, default 32: width of each performance counter.
- `clk`  in  1  sole clock; everything is sampled on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `opcode_ID`  in  7  opcode of the instruction in ID.
- `rs1_ID`, `rs2_ID`  in  5 each  source register indices in ID.
- `rd_EX`  in  5  destination register index in EX.
- `reg_write_EX`  in  1  EX instruction writes the register file.
- `result_sel_EX`  in  2  EX writeback source; `RESULT_SEL_MEM` marks a load.
- `redirect_EX`  in  1  taken branch or JAL/JALR resolved in EX.
- `mem_busy_MEM`  in  1  data memory cannot complete the MEM-stage access this cycle.
- `stall_IF`, `stall_ID`, `stall_EX`, `stall_MEM`  out  1 each  hold PC, IF/ID, ID/EX and EX/MEM respectively.
- `flush_ID`, `flush_EX`  out  1 each  load a bubble into IF/ID and ID/EX respectively.
- `mem_timeout`  out  1  sticky watchdog error.
- `cnt_stall`, `cnt_flush`, `cnt_lu`  out  `CNT_WIDTH` each  performance counters (only with `HAZARD_PERF_EN`).

## Operation
- **Source-register usage is decoded from `opcode_ID`:**
  - R-type, store and branch use rs1 and rs2.
  - OP-IMM, load and JALR use rs1 only.
  - LUI, AUIPC, JAL and unknown opcodes use neither.
- **Load-use hazard (`lu`):** all of the following hold:
  - `reg_write_EX` is 1,
  - `result_sel_EX` equals `RESULT_SEL_MEM`,
  - `rd_EX` is not 0,
  - `rd_EX` matches a used rs.
- **FSM states:** RESET_FLUSH, RUN, MEM_WAIT.
- **RESET_FLUSH:** this state is held while `rst` is high, plus exactly one cycle after release.
  - Outputs: `flush_ID`=`flush_EX`=1, all stalls 0.
  - Next state: RUN.
- **RUN:** conditions are evaluated in this priority order.
  1. `mem_busy_MEM`: all four stalls 1, flushes 0. Next state MEM_WAIT. The watchdog count loads 1.
  2. `redirect_EX`: `flush_ID`=`flush_EX`=1, stalls 0. Next state RUN.
  3. `lu`: `stall_IF`=`stall_ID`=1, `flush_EX`=1, `stall_EX`=`stall_MEM`=0. Next state RUN.
  4. Otherwise all outputs are 0.
- **MEM_WAIT:** stall and flush outputs are Mealy on `mem_busy_MEM`.
  - While busy: all stalls 1, flushes 0, and the watchdog count increments, saturating at `MEM_TIMEOUT`.
  - In the cycle busy drops: outputs follow the RUN rules for that cycle (redirect, then lu, then idle), and the next state is RUN.
  - Busy dropping for one cycle then reasserting re-enters MEM_WAIT through RUN; the watchdog reloads 1.
- **Redirect during a busy cycle:** no flush is issued while busy. EX is frozen, so `redirect_EX` persists and is honoured in the release cycle.
- **Watchdog:** `mem_timeout` sets when the count reaches `MEM_TIMEOUT` while still busy. It stays set until `rst`, and has no effect on the stall outputs.
- **Reset mid-operation:** any state goes to RESET_FLUSH. The watchdog and counters clear.

## Timing
- **Latency:** stall and flush outputs are combinational from inputs plus the registered state, so they are valid in the same cycle as the cause. No additional latency is allowed.
- **Reset values (while `rst` is high):**
  - `flush_ID`=`flush_EX`=1.
  - `stall_*`=0.
  - `mem_timeout`=0 and counters=0.
- **Load-use bubble:** exactly one cycle per hazard. After it, the load is in MEM and `lu` is false (EX holds the bubble).
- **Flush length:** a redirect flushes for exactly one cycle.
- **Stall/flush exclusivity:** `stall_EX`/`stall_MEM` and `flush_EX` are never 1 together. `stall_ID` and `flush_ID` are never 1 together.
- **State register:** 2 bits. The watchdog count is 16 bits.

## Configuration
- **`HAZARD_PERF_EN` defined:** the three counters exist. Each increments at most once per cycle and saturates at all-ones. Increment conditions:
  - `cnt_stall`: `stall_IF` is 1.
  - `cnt_flush`: `flush_ID` is 1 and the state is not RESET_FLUSH.
  - `cnt_lu`: a load-use bubble is issued.
- **`HAZARD_PERF_EN` undefined:** the counter ports are absent and no counter logic is generated.

## Structure
- **Shared package:** `riscv_defs` holds the opcode constants, `RESULT_SEL_MEM` (2'b01) and the FSM state encoding.
- **Sub-module `hazard_perf_cnt`:** one instance, wrapped in `HAZARD_PERF_EN`. Its inputs are the three increment strobes; its outputs are the three counters.

## Test plan
- **Reset release:** deassert `rst`. Require flushes=1 for one cycle, then all outputs 0.
- **Load-use:** load x5 in EX (`reg_write_EX`=1, `result_sel_EX`=01), `add x6,x5,x7` in ID. Require exactly one cycle of `stall_IF`=`stall_ID`=`flush_EX`=1. Repeat with `rd_EX`=0 and with `lui` in ID: require no stall.
- **Redirect vs load-use:** `redirect_EX`=1 together with `lu`. Require `flush_ID`=`flush_EX`=1, `stall_IF`=0.
- **Memory busy:** `mem_busy_MEM` high for 3 cycles. Require 3 cycles of all stalls, then release. With `redirect_EX` held high, require the flush only in the release cycle.
- **Watchdog:** `MEM_TIMEOUT`=4, busy held for 10 cycles. Require `mem_timeout` to rise in the 4th busy cycle and stay high until `rst`.
- **Performance counters:** with `HAZARD_PERF_EN`, run the scenarios above. Require `cnt_lu`=1, `cnt_flush`=2, and `cnt_stall` equal to the stall-cycle sum. Also check saturation with `CNT_WIDTH`=3.
